flag_int_seq: RTL

- Sequencer for the C/Z flag register and its shadow copy.
- Decodes per-instruction flag operations into the flag register's control strobes (C set/clear/load, Z load, load-select, shadow load).
- Owns the interrupt-enable (I) flag and runs the multi-cycle interrupt entry (save flags, vector) and return (restore flags) sequences.
- Sits between the control unit's decode stage and the flag register; stalls fetch while sequencing.

---
 rtl/flag_int_seq_if.sv | 28 ++
 rtl/flag_int_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/flag_int_seq_if.sv
// Decode-side bus between the control unit and the flag/interrupt sequencer.
// Signal names match the control unit's existing pin names.
interface flag_int_seq_if;
    logic       INSTR_VLD;
    logic [3:0] FLG_OP;
    logic       INTR;
    logic       FLG_C_SET;
    logic       FLG_C_CLR;
    logic       FLG_C_LD;
    logic       FLG_Z_LD;
    logic       FLG_LD_SEL;
    logic       FLG_SHAD_LD;
    logic       I_FLAG;
    logic       INT_ACK;
    logic       STALL;

    modport master (
        output INSTR_VLD, FLG_OP, INTR,
        input  FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
               FLG_SHAD_LD, I_FLAG, INT_ACK, STALL
    );

    modport slave (
        input  INSTR_VLD, FLG_OP, INTR,
        output FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
               FLG_SHAD_LD, I_FLAG, INT_ACK, STALL
    );
endinterface

// File: rtl/flag_int_seq.sv
// C/Z flag strobe decoder, interrupt-enable owner and interrupt entry/return sequencer.
//
// state    | meaning
// RUN      | normal execution, interrupt check and flag-op decode
// INT_SAVE | copy C/Z into shadow, drop I
// INT_VEC  | vector pulse, clear C
// RET_REST | reload C/Z from shadow, restore I, arm guard
module flag_int_seq #(
    parameter int unsigned GUARD_INSTR = 1
) (
    input logic           CLK,
    input logic           RST_N,
    flag_int_seq_if.slave bus
);

    localparam int unsigned GW = (GUARD_INSTR > 0) ? $clog2(GUARD_INSTR + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_INSTR);

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_LD_CZ = 4'd1;
    localparam logic [3:0] OP_LD_Z  = 4'd2;
    localparam logic [3:0] OP_SEC   = 4'd3;
    localparam logic [3:0] OP_CLC   = 4'd4;
    localparam logic [3:0] OP_RETID = 4'd5;
    localparam logic [3:0] OP_RETIE = 4'd6;
    localparam logic [3:0] OP_SEI   = 4'd7;
    localparam logic [3:0] OP_CLI   = 4'd8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        INT_SAVE = 2'd1,
        INT_VEC  = 2'd2,
        RET_REST = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            i_flag_q, i_flag_d;
    logic [GW-1:0]   guard_q, guard_d;
    logic            ret_ie_q, ret_ie_d;

    logic accept;
    logic c_set, c_clr, c_ld, z_ld, ld_sel, shad_ld, int_ack, stall;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= RUN;
            i_flag_q <= 1'b0;
            guard_q  <= '0;
            ret_ie_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
            guard_q  <= guard_d;
            ret_ie_q <= ret_ie_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_flag_d = i_flag_q;
        guard_d  = guard_q;
        ret_ie_d = ret_ie_q;
        accept   = 1'b0;
        c_set    = 1'b0;
        c_clr    = 1'b0;
        c_ld     = 1'b0;
        z_ld     = 1'b0;
        ld_sel   = 1'b0;
        shad_ld  = 1'b0;
        int_ack  = 1'b0;
        stall    = 1'b0;

        case (state_q)
            RUN: begin
                accept = bus.INTR && i_flag_q && (guard_q == '0);
                // An accepted interrupt drops the instruction; decode re-presents it later.
                if (accept) begin
                    stall   = 1'b1;
                    state_d = INT_SAVE;
                end else if (bus.INSTR_VLD) begin
                    if (guard_q != '0) begin
                        guard_d = guard_q - GW'(1);
                    end
                    case (bus.FLG_OP)
                        OP_LD_CZ: begin
                            c_ld = 1'b1;
                            z_ld = 1'b1;
                        end
                        OP_LD_Z:  z_ld  = 1'b1;
                        OP_SEC:   c_set = 1'b1;
                        OP_CLC:   c_clr = 1'b1;
                        OP_RETID, OP_RETIE: begin
                            stall    = 1'b1;
                            ret_ie_d = (bus.FLG_OP == OP_RETIE);
                            state_d  = RET_REST;
                        end
                        OP_SEI:   i_flag_d = 1'b1;
                        OP_CLI:   i_flag_d = 1'b0;
                        OP_NONE:  ;
                        default:  ;
                    endcase
                end
            end
            INT_SAVE: begin
                shad_ld  = 1'b1;
                stall    = 1'b1;
                i_flag_d = 1'b0;
                state_d  = INT_VEC;
            end
            INT_VEC: begin
                int_ack = 1'b1;
                c_clr   = 1'b1;
                stall   = 1'b1;
                state_d = RUN;
            end
            RET_REST: begin
                ld_sel   = 1'b1;
                c_ld     = 1'b1;
                z_ld     = 1'b1;
                stall    = 1'b1;
                i_flag_d = ret_ie_q;
                guard_d  = GUARD_LOAD;
                state_d  = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs held low during reset; I_FLAG is gated too so it never shows X before the first edge.
    assign bus.FLG_C_SET   = RST_N & c_set;
    assign bus.FLG_C_CLR   = RST_N & c_clr;
    assign bus.FLG_C_LD    = RST_N & c_ld;
    assign bus.FLG_Z_LD    = RST_N & z_ld;
    assign bus.FLG_LD_SEL  = RST_N & ld_sel;
    assign bus.FLG_SHAD_LD = RST_N & shad_ld;
    assign bus.INT_ACK     = RST_N & int_ack;
    assign bus.STALL       = RST_N & stall;
    assign bus.I_FLAG      = RST_N & i_flag_q;

endmodule
